// File: rtl/spi_ram_pkg.sv
// Shared command-word layout, opcode encoding and controller state type for the SPI RAM block.
`timescale 1ns/1ps
package spi_ram_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_e;

  // Command word as delivered by the SPI slave: opcode on top, payload below.
  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI slave (master modport) and the RAM controller (slave modport).
`timescale 1ns/1ps
interface spi_ram_ctrl_if;
  import spi_ram_pkg::*;

  logic [CMD_W-1:0]  rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              addr_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, addr_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, addr_err
  );
endinterface

// File: rtl/spram_core.sv
// Single-port byte RAM: synchronous write, registered read sharing one address port.
`timescale 1ns/1ps
module spram_core
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder driving a byte RAM; returns read data with a held tx_valid.
// Optional build macro SPI_RAM_AUTO_INC_EN: post-increment addresses after data writes/reads.
`timescale 1ns/1ps
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input logic           clk,
  input logic           rst,
  spi_ram_ctrl_if.slave bus
);

  if (MEM_DEPTH != (32'(1) << ADDR_SIZE)) begin : g_depth_check
    $error("spi_ram_ctrl: MEM_DEPTH must equal 2**ADDR_SIZE");
  end
  if (ADDR_SIZE > DATA_W) begin : g_width_check
    $error("spi_ram_ctrl: ADDR_SIZE must not exceed the payload width");
  end

  state_e               r_state;
  logic                 r_active;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_rd_addr_loaded;
  logic                 r_addr_err;

  cmd_t                 w_cmd;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_re;
  logic [ADDR_SIZE-1:0] w_addr_pl;
  logic [ADDR_SIZE-1:0] w_mem_addr;
  logic [DATA_W-1:0]    w_rdata;

  // r_active stays low on the edge that releases reset, so a coincident command is dropped.
  assign w_cmd      = cmd_t'(bus.rx_data);
  assign w_accept   = bus.rx_valid & r_active;
  assign w_we       = w_accept & (w_cmd.op == OP_WR_DATA);
  assign w_re       = w_accept & (w_cmd.op == OP_RD_DATA);
  assign w_addr_pl  = w_cmd.payload[ADDR_SIZE-1:0];
  assign w_mem_addr = w_re ? r_rd_addr : r_wr_addr;

  spram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_cmd.payload),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_active         <= 1'b0;
      r_wr_addr        <= '0;
      r_rd_addr        <= '0;
      r_rd_addr_loaded <= 1'b0;
      r_addr_err       <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_accept) begin
        case (w_cmd.op)
          OP_WR_ADDR: begin
            r_wr_addr <= w_addr_pl;
            r_state   <= IDLE;
          end
          OP_WR_DATA: begin
`ifdef SPI_RAM_AUTO_INC_EN
            r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
`endif
            r_state   <= IDLE;
          end
          OP_RD_ADDR: begin
            r_rd_addr        <= w_addr_pl;
            r_rd_addr_loaded <= 1'b1;
            r_state          <= IDLE;
          end
          OP_RD_DATA: begin
`ifdef SPI_RAM_AUTO_INC_EN
            r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
`endif
            // A read without a loaded read address still completes, but is flagged until reset.
            if (!r_rd_addr_loaded) begin
              r_addr_err <= 1'b1;
            end
            r_state <= TX_HOLD;
          end
        endcase
      end
    end
  end

  assign bus.tx_valid = (r_state == TX_HOLD);
  assign bus.tx_data  = w_rdata;
  assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus a randomized command stream vs a behavioural model.
`timescale 1ns/1ps
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_ctrl_if bus ();

  spi_ram_ctrl #(
    .MEM_DEPTH (DEPTH),
    .ADDR_SIZE (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: what the controller must present after each accepted command.
  logic [7:0]    m_mem [DEPTH];
  logic [AW-1:0] m_wr;
  logic [AW-1:0] m_rd;
  bit            m_loaded;
  bit            m_txv;
  bit            m_err;
  logic [7:0]    m_tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = '0; m_rd = '0; m_loaded = 1'b0;
    m_txv = 1'b0; m_err = 1'b0; m_tx = 8'h00;
  endtask

  task automatic model_apply(input op_e op, input logic [7:0] pl);
    m_txv = (op == OP_RD_DATA);
    case (op)
      OP_WR_ADDR: m_wr = pl[AW-1:0];
      OP_WR_DATA: begin
        m_mem[m_wr] = pl;
`ifdef SPI_RAM_AUTO_INC_EN
        m_wr = AW'((int'(m_wr) + 1) % DEPTH);
`endif
      end
      OP_RD_ADDR: begin
        m_rd = pl[AW-1:0];
        m_loaded = 1'b1;
      end
      OP_RD_DATA: begin
        m_tx = m_mem[m_rd];
        if (!m_loaded) m_err = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
        m_rd = AW'((int'(m_rd) + 1) % DEPTH);
`endif
      end
    endcase
  endtask

  // One rx_valid pulse, sampled at the next rising edge.
  task automatic send(input op_e op, input logic [7:0] pl);
    @(negedge clk);
    bus.rx_data  = {op, pl};
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    model_apply(op, pl);
  endtask

  // Short asynchronous reset between clock edges; memory must survive it.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #0.5;
    check("async_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("async_rst_tx_data",  32'(bus.tx_data),  32'h00);
    #0.5;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
      check("addr_err", 32'(bus.addr_err), 32'(m_err));
      check("tx_data",  32'(bus.tx_data),  32'(m_tx));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_tx_data",  32'(bus.tx_data),  32'h00);
    check("reset_addr_err", 32'(bus.addr_err), 32'd0);

    // Read command coincident with reset release must be ignored.
    bus.rx_data  = {OP_RD_DATA, 8'h00};
    bus.rx_valid = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    #1;
    bus.rx_valid = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_release_ignored_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_release_ignored_err",   32'(bus.addr_err), 32'd0);

    // Read without a loaded read address uses address 0 and flags addr_err.
    send(OP_WR_ADDR, 8'h00);
    send(OP_WR_DATA, 8'h5A);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("noaddr_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("noaddr_tx_data",  32'(bus.tx_data),  32'h5A);
    check("noaddr_addr_err", 32'(bus.addr_err), 32'd1);
    for (int i = 0; i < 20; i++) begin
      send(op_e'(2'($urandom_range(0, 2))), 8'($urandom));
    end
    @(negedge clk);
    check("addr_err_sticky", 32'(bus.addr_err), 32'd1);

    // Give every location a known value so random reads are predictable.
    for (int a = 0; a < int'(DEPTH); a++) begin
      send(OP_WR_ADDR, 8'(a));
      send(OP_WR_DATA, 8'($urandom));
    end
    pulse_reset();

    send(OP_WR_ADDR, 8'h12);
    send(OP_WR_DATA, 8'hA5);
    send(OP_RD_ADDR, 8'h12);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("basic_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("basic_tx_data",  32'(bus.tx_data),  32'hA5);
    check("basic_addr_err", 32'(bus.addr_err), 32'd0);

`ifndef SPI_RAM_AUTO_INC_EN
    send(OP_WR_DATA, 8'h3C);
    @(negedge clk);
    check("write_drops_valid", 32'(bus.tx_valid), 32'd0);
    check("write_holds_data",  32'(bus.tx_data),  32'hA5);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("coherent_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("coherent_tx_data",  32'(bus.tx_data),  32'h3C);
    pulse_reset();
    send(OP_RD_ADDR, 8'h12);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("retained_tx_data", 32'(bus.tx_data), 32'h3C);
`else
    send(OP_WR_ADDR, 8'hFF);
    send(OP_WR_DATA, 8'h11);
    send(OP_WR_DATA, 8'h22);
    send(OP_RD_ADDR, 8'hFF);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("autoinc_mem_ff", 32'(bus.tx_data), 32'h11);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("autoinc_mem_00", 32'(bus.tx_data), 32'h22);
    pulse_reset();
    send(OP_RD_ADDR, 8'h00);
    send(OP_RD_DATA, 8'h00);
    @(negedge clk);
    check("retained_tx_data", 32'(bus.tx_data), 32'h22);
`endif

    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send(op_e'(2'($urandom_range(0, 3))), 8'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit words stored.
REQ-002 Parameter ADDR_SIZE, default 8, address width; the block SHALL require MEM_DEPTH = 2**ADDR_SIZE.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  10  command word from the SPI slave; [9:8] opcode, [7:0] payload.
REQ-006 rx_valid  input  1  rx_data is valid this cycle; single-cycle pulse per command.
REQ-007 tx_data  output  8  read data returned to the SPI slave.
REQ-008 tx_valid  output  1  tx_data is valid and stable.
REQ-009 addr_err  output  1  sticky flag: read issued with no read address loaded since reset.

Function
REQ-010 The block SHALL act on rx_data only at a rising edge where rx_valid=1; otherwise the state is held.
REQ-011 Opcode 00: wr_addr SHALL load rx_data[ADDR_SIZE-1:0]; memory is unchanged.
REQ-012 Opcode 01: mem[wr_addr] SHALL load rx_data[7:0] at the same edge.
REQ-013 Opcode 10: rd_addr SHALL load rx_data[ADDR_SIZE-1:0] and set internal rd_addr_loaded.
REQ-014 Opcode 11: tx_data SHALL load mem[rd_addr] and tx_valid SHALL be 1 from the same edge, so tx_valid is visible one cycle after the rx_valid pulse.
REQ-015 FSM states: IDLE (tx_valid=0) and TX_HOLD (tx_valid=1); IDLE->TX_HOLD on accepted opcode 11; TX_HOLD->IDLE on any other accepted opcode; TX_HOLD->TX_HOLD with tx_data reloaded on opcode 11.
REQ-016 In TX_HOLD, tx_data SHALL stay stable until the next accepted command, including a write to mem[rd_addr].
REQ-017 Opcode 01 with wr_addr equal to rd_addr, followed by opcode 11, SHALL return the newly written value (write-then-read coherence).
REQ-018 Opcode 11 with rd_addr_loaded=0 SHALL still return mem[rd_addr] with rd_addr=0, and SHALL set addr_err.
REQ-019 addr_err SHALL be cleared only by reset.
REQ-020 Payload bits [7:ADDR_SIZE] SHALL be ignored when ADDR_SIZE<8.

Reset
REQ-021 While rst=1: tx_valid=0, tx_data=8'h00, addr_err=0, wr_addr=0, rd_addr=0, rd_addr_loaded=0, FSM=IDLE.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset asserted mid-TX_HOLD SHALL drop tx_valid immediately (asynchronously), not at the next clock edge.
REQ-024 An rx_valid pulse coincident with the rst deassertion edge SHALL be ignored.

Configuration
REQ-025 Macro SPI_RAM_AUTO_INC_EN: when defined, wr_addr SHALL increment after each opcode 01 and rd_addr after each opcode 11, wrapping MEM_DEPTH-1 -> 0.
REQ-026 When SPI_RAM_AUTO_INC_EN is undefined, addresses SHALL change only on opcodes 00 and 10.

Structure
REQ-027 Package spi_ram_pkg SHALL hold the opcode constants (OP_WR_ADDR=00, OP_WR_DATA=01, OP_RD_ADDR=10, OP_RD_DATA=11) and the FSM state typedef.
REQ-028 Storage SHALL be a sub-module spram_core: single-port, synchronous write, registered read, one port shared between read and write.
REQ-029 Command decode, the address registers and the FSM SHALL reside in spi_ram_ctrl.

Verification
REQ-030 Reset, then {00,0x12} / {01,0xA5} / {10,0x12} / {11,xx} -> tx_valid=1 with tx_data=0xA5 one cycle after the last rx_valid; addr_err=0.
REQ-031 In TX_HOLD with tx_data=0xA5, issue {01,0x3C} to the same address -> tx_valid falls on that edge; a following {11,xx} -> tx_data=0x3C.
REQ-032 After reset, issue {11,xx} with no prior opcode 10 -> addr_err=1 and rd_addr=0 is used; addr_err stays 1 through 20 further commands.
REQ-033 With SPI_RAM_AUTO_INC_EN defined: {00,0xFF}, {01,0x11}, {01,0x22} -> mem[0xFF]=0x11, mem[0x00]=0x22.
REQ-034 Assert rst for 1 ns mid-TX_HOLD, off a clock edge -> tx_valid=0 and tx_data=0x00 immediately; memory contents are retained.
REQ-035 Random opcode streams checked against a reference model, with idle gaps of 0-5 cycles between rx_valid pulses.
